// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2-to-matrix keyboard mapper and its combo slots.
package kbd_pkg;

   localparam int unsigned KEY_TOG_BIT = 10;
   localparam int unsigned KEY_PRS_BIT = 9;
   localparam int unsigned KEY_EXT_BIT = 8;
   localparam int unsigned KEY_CODE_W  = 8;
   localparam int unsigned KEY_W       = 11;
   localparam int unsigned TAG_W       = 9;

   localparam int unsigned MOD_W       = 3;
   localparam int unsigned MOD_SHIFT   = 0;
   localparam int unsigned MOD_CTRL    = 1;
   localparam int unsigned MOD_ALT     = 2;

   localparam int unsigned IDX_MAX_W   = 16;
   localparam int unsigned CNT_W       = 8;

   typedef struct packed {
      logic                 valid;
      logic                 combo;
      logic [MOD_W-1:0]     mod;
      logic [IDX_MAX_W-1:0] idx;
   } kbd_entry_t;

   typedef enum logic [1:0] {
      SlotFree   = 2'd0,
      SlotWait   = 2'd1,
      SlotActive = 2'd2
   } slot_state_e;

endpackage

// File: rtl/kbd_combo_slot.sv
// One combo slot: holds the key tag, modifier mask and delayed main key index of a held combo.
// Modifiers are driven while busy; the main key only once the tick count reaches COMBO_DELAY.
module kbd_combo_slot
   import kbd_pkg::*;
#(
   parameter int unsigned IDXW        = 6,
   parameter int unsigned COMBO_DELAY = 15
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_clr,
   input  logic             i_tick,
   input  logic             i_alloc,
   input  logic             i_free,
   input  logic [TAG_W-1:0] i_tag,
   input  logic [IDXW-1:0]  i_idx,
   input  logic [MOD_W-1:0] i_mod,
   output logic             o_busy,
   output logic [TAG_W-1:0] o_tag,
   output logic [IDXW-1:0]  o_idx,
   output logic [MOD_W-1:0] o_mod,
   output logic             o_main
);

   slot_state_e      r_state, w_state_d;
   logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
   logic [TAG_W-1:0] r_tag, w_tag_d;
   logic [IDXW-1:0]  r_idx, w_idx_d;
   logic [MOD_W-1:0] r_mod, w_mod_d;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= SlotFree;
         r_cnt   <= '0;
         r_tag   <= '0;
         r_idx   <= '0;
         r_mod   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_tag   <= w_tag_d;
         r_idx   <= w_idx_d;
         r_mod   <= w_mod_d;
      end
   end

   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_tag_d   = r_tag;
      w_idx_d   = r_idx;
      w_mod_d   = r_mod;
      if (i_clr) begin
         w_state_d = SlotFree;
         w_cnt_d   = '0;
      end else begin
         case (r_state)
            SlotFree: begin
               if (i_alloc) begin
                  w_state_d = SlotWait;
                  w_cnt_d   = '0;
                  w_tag_d   = i_tag;
                  w_idx_d   = i_idx;
                  w_mod_d   = i_mod;
               end
            end
            SlotWait: begin
               // A release in the same cycle as the final tick wins: the main key never shows.
               if (i_free) begin
                  w_state_d = SlotFree;
               end else if (i_tick) begin
                  w_cnt_d = w_cnt_inc;
                  if (w_cnt_inc == CNT_W'(COMBO_DELAY)) begin
                     w_state_d = SlotActive;
                  end
               end
            end
            SlotActive: begin
               if (i_free) begin
                  w_state_d = SlotFree;
               end
            end
            default: w_state_d = SlotFree;
         endcase
      end
   end

   always_comb begin
      o_busy = (r_state != SlotFree);
      o_tag  = r_tag;
      o_idx  = r_idx;
      o_mod  = o_busy ? r_mod : '0;
      o_main = (r_state == SlotActive);
   end

endmodule

// File: rtl/kbd_matrix_mapper.sv
// PS/2 make/break events to ROWS x COLS key matrix through a loadable table, with delayed combos.
// Optional joystick overlay is built in when KBD_JOYSTICK_EN is defined.
module kbd_matrix_mapper
   import kbd_pkg::*;
#(
   parameter int unsigned ROWS        = 8,
   parameter int unsigned COLS        = 8,
   parameter int unsigned N_COMBO     = 4,
   parameter int unsigned PRESCALE    = 1024,
   parameter int unsigned COMBO_DELAY = 15,
   localparam int unsigned IDXW       = $clog2(ROWS * COLS),
   parameter logic [3*IDXW-1:0] MOD_IDX = {IDXW'(58), IDXW'(57), IDXW'(56)}
`ifdef KBD_JOYSTICK_EN
   ,
   parameter logic [5*IDXW-1:0] JOY_IDX = {IDXW'(14), IDXW'(10), IDXW'(15), IDXW'(9), IDXW'(12)}
`endif
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic [KEY_W-1:0]     i_ps2_key,
   input  logic                 i_clr,
   input  logic                 i_map_we,
   input  logic [TAG_W-1:0]     i_map_addr,
   input  logic [IDXW+4:0]      i_map_data,
   output logic [ROWS*COLS-1:0] o_matrix,
   input  logic [ROWS-1:0]      i_row_sel,
   output logic [COLS-1:0]      o_col_out,
   output logic                 o_any_key,
`ifdef KBD_JOYSTICK_EN
   input  logic [4:0]           i_joy,
`endif
   output logic                 o_drop
);

   localparam int unsigned NBITS = ROWS * COLS;
   localparam int unsigned PREW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [IDXW+4:0]    r_tbl [2**TAG_W];
   logic [IDXW+4:0]    r_rd;
   logic               r_tog, r_ev, r_ev_prs;
   logic [TAG_W-1:0]   r_ev_tag;
   logic [NBITS-1:0]   r_normal, w_normal_d, w_matrix;
   logic [PREW-1:0]    r_pre;
   logic [COLS-1:0]    r_col, w_col;
   logic               r_any, r_drop;

   logic               w_event, w_tick, w_apply, w_in_range, w_press, w_rel, w_hit, w_full;
   kbd_entry_t         w_entry;
   logic [IDXW-1:0]    w_idx;

   logic [N_COMBO-1:0] w_busy, w_main, w_match, w_first_free, w_alloc, w_free;
   logic [TAG_W-1:0]   w_slot_tag [N_COMBO];
   logic [IDXW-1:0]    w_slot_idx [N_COMBO];
   logic [MOD_W-1:0]   w_slot_mod [N_COMBO];

   // Table RAM: registered read, so a same-cycle write is seen only by later lookups.
   always_ff @(posedge i_clk) begin
      if (i_map_we) begin
         r_tbl[i_map_addr] <= i_map_data;
      end
      r_rd <= r_tbl[i_ps2_key[TAG_W-1:0]];
   end

   assign w_event = i_ps2_key[KEY_TOG_BIT] ^ r_tog;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_tog    <= i_ps2_key[KEY_TOG_BIT];
         r_ev     <= 1'b0;
         r_ev_prs <= 1'b0;
         r_ev_tag <= '0;
      end else begin
         r_tog    <= i_ps2_key[KEY_TOG_BIT];
         r_ev     <= w_event;
         r_ev_prs <= i_ps2_key[KEY_PRS_BIT];
         r_ev_tag <= i_ps2_key[TAG_W-1:0];
      end
   end

   always_comb begin
      w_entry       = '0;
      w_entry.valid = r_rd[IDXW+4];
      w_entry.combo = r_rd[IDXW+3];
      w_entry.mod   = r_rd[IDXW+2:IDXW];
      w_entry.idx   = IDX_MAX_W'(r_rd[IDXW-1:0]);
   end

   assign w_idx      = w_entry.idx[IDXW-1:0];
   assign w_in_range = (w_entry.idx < IDX_MAX_W'(NBITS));
   assign w_apply    = r_ev & w_entry.valid & w_in_range & ~i_clr;
   assign w_press    = w_apply & w_entry.combo & r_ev_prs;
   assign w_rel      = w_apply & w_entry.combo & ~r_ev_prs;

   always_comb begin
      w_normal_d = r_normal;
      if (w_apply && !w_entry.combo) begin
         w_normal_d[w_idx] = r_ev_prs;
      end
   end

   assign w_tick = (r_pre == PREW'(PRESCALE - 1));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_normal <= '0;
         r_pre    <= '0;
         r_drop   <= 1'b0;
      end else begin
         r_normal <= i_clr ? '0 : w_normal_d;
         r_pre    <= w_tick ? '0 : r_pre + PREW'(1);
         r_drop   <= w_press & ~w_hit & w_full;
      end
   end

   // Slot allocation: typematic repeats hit an existing slot, new presses take the lowest free one.
   always_comb begin
      for (int s = 0; s < int'(N_COMBO); s++) begin
         w_match[s] = w_busy[s] && (w_slot_tag[s] == r_ev_tag);
      end
   end

   always_comb begin
      w_first_free = '0;
      for (int s = int'(N_COMBO) - 1; s >= 0; s--) begin
         if (!w_busy[s]) begin
            w_first_free    = '0;
            w_first_free[s] = 1'b1;
         end
      end
   end

   assign w_hit   = |w_match;
   assign w_full  = &w_busy;
   assign w_alloc = (w_press && !w_hit) ? w_first_free : '0;
   assign w_free  = w_rel ? w_match : '0;

   for (genvar g = 0; g < int'(N_COMBO); g++) begin : g_slot
      kbd_combo_slot #(
         .IDXW        (IDXW),
         .COMBO_DELAY (COMBO_DELAY)
      ) u_slot (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_clr     (i_clr),
         .i_tick    (w_tick),
         .i_alloc   (w_alloc[g]),
         .i_free    (w_free[g]),
         .i_tag     (r_ev_tag),
         .i_idx     (w_idx),
         .i_mod     (w_entry.mod),
         .o_busy    (w_busy[g]),
         .o_tag     (w_slot_tag[g]),
         .o_idx     (w_slot_idx[g]),
         .o_mod     (w_slot_mod[g]),
         .o_main    (w_main[g])
      );
   end

   always_comb begin
      w_matrix = r_normal;
      for (int s = 0; s < int'(N_COMBO); s++) begin
         for (int m = 0; m < int'(MOD_W); m++) begin
            if (w_slot_mod[s][m]) begin
               w_matrix[MOD_IDX[m*IDXW +: IDXW]] = 1'b1;
            end
         end
         if (w_main[s]) begin
            w_matrix[w_slot_idx[s]] = 1'b1;
         end
      end
`ifdef KBD_JOYSTICK_EN
      for (int j = 0; j < 5; j++) begin
         if (i_joy[j]) begin
            w_matrix[JOY_IDX[j*IDXW +: IDXW]] = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      w_col = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
         if (i_row_sel[r]) begin
            w_col = w_col | w_matrix[r*COLS +: COLS];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_col <= '0;
         r_any <= 1'b0;
      end else begin
         r_col <= w_col;
         r_any <= |w_matrix;
      end
   end

   assign o_matrix  = w_matrix;
   assign o_col_out = r_col;
   assign o_any_key = r_any;
   assign o_drop    = r_drop;

endmodule
